// File: rtl/tto_output_monitor.sv
// -----------------------------------------------------------------------------
// tto_output_monitor
//
// Board-side readback path for the TinyTapeout DUT. The DUT output bus is
// sampled once per divided DUT clock period (on the clk_dut falling edge, mid
// DUT cycle). Samples are buffered in a small circular FIFO and streamed to the
// host as 8N1 UART frames, LSB first.
//
// Parameters:
//   CLKS_PER_BIT    CLK cycles per UART bit (2..65535)
//   FIFO_DEPTH_LOG2 log2 of the FIFO depth
//   CHANGE_ONLY     1: enqueue only samples that differ from the last enqueued
//                   0: enqueue every sample
//
// Ports:
//   CLK       board clock, all logic on posedge
//   rst       asynchronous active-high reset
//   clk_dut   divided DUT clock, generated in the CLK domain
//   dut_out   DUT output bus
//   tx        UART transmit, idle high (registered)
//   busy      FIFO non-empty or frame in progress (registered)
//   overflow  sticky, a wanted sample was dropped because the FIFO was full
// -----------------------------------------------------------------------------
module tto_output_monitor #(
    parameter int unsigned CLKS_PER_BIT    = 104,
    parameter int unsigned FIFO_DEPTH_LOG2 = 2,
    parameter bit          CHANGE_ONLY     = 1'b1
) (
    input  logic       CLK,
    input  logic       rst,
    input  logic       clk_dut,
    input  logic [7:0] dut_out,
    output logic       tx,
    output logic       busy,
    output logic       overflow
);

    localparam int unsigned DEPTH = 1 << FIFO_DEPTH_LOG2;
    localparam int unsigned PW    = FIFO_DEPTH_LOG2;
    localparam int unsigned CW    = FIFO_DEPTH_LOG2 + 1;
    localparam int unsigned BW    = 16;

    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);
    localparam logic [2:0]    LAST_BIT  = 3'd7;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    // ---------------------------------------------------------------------
    // Registers
    // ---------------------------------------------------------------------
    logic          clk_dut_q;
    logic [7:0]    last_val;
    logic          last_valid;

    logic [7:0]    mem [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count;

    state_t        state;
    logic [BW-1:0] baud;
    logic [2:0]    bit_idx;
    logic [7:0]    sh;

    // ---------------------------------------------------------------------
    // Next-state / control signals
    // ---------------------------------------------------------------------
    logic          sample_stb;
    logic          want;
    logic          full;
    logic          pop;
    logic          push;
    logic          drop;

    logic [CW-1:0] count_d;
    state_t        state_d;
    logic [BW-1:0] baud_d;
    logic [2:0]    bit_idx_d;
    logic [7:0]    sh_d;
    logic          tx_d;
    logic          busy_d;

    // clk_dut falling edge: DUT outputs are settled half a DUT cycle after rise
    assign sample_stb = ~clk_dut & clk_dut_q;

    // Enqueue decision and FIFO handshake
    always_comb begin
        want = 1'b0;
        full = 1'b0;
        pop  = 1'b0;
        push = 1'b0;
        drop = 1'b0;

        full = (count == FULL_CNT);
        pop  = (state == S_IDLE) && (count != '0);
        if (sample_stb) begin
            want = !CHANGE_ONLY || !last_valid || (dut_out != last_val);
        end
        // A full FIFO still accepts if the head leaves on the same edge
        push = want && (!full || pop);
        drop = want && !push;
    end

    // FIFO occupancy
    always_comb begin
        count_d = count;
        unique case ({push, pop})
            2'b10:   count_d = count + CW'(1);
            2'b01:   count_d = count - CW'(1);
            default: count_d = count;
        endcase
    end

    // UART transmitter: next state, baud/bit counters, shift register
    always_comb begin
        state_d   = state;
        baud_d    = baud;
        bit_idx_d = bit_idx;
        sh_d      = sh;

        unique case (state)
            S_IDLE: begin
                if (pop) begin
                    state_d = S_START;
                    baud_d  = '0;
                    sh_d    = mem[rd_ptr];
                end
            end
            S_START: begin
                if (baud == BAUD_LAST) begin
                    state_d   = S_DATA;
                    baud_d    = '0;
                    bit_idx_d = '0;
                end else begin
                    baud_d = baud + BW'(1);
                end
            end
            S_DATA: begin
                if (baud == BAUD_LAST) begin
                    baud_d = '0;
                    sh_d   = {1'b0, sh[7:1]};
                    if (bit_idx == LAST_BIT) begin
                        state_d = S_STOP;
                    end else begin
                        bit_idx_d = bit_idx + 3'd1;
                    end
                end else begin
                    baud_d = baud + BW'(1);
                end
            end
            S_STOP: begin
                if (baud == BAUD_LAST) begin
                    state_d = S_IDLE;
                    baud_d  = '0;
                end else begin
                    baud_d = baud + BW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                baud_d  = '0;
            end
        endcase
    end

    // Line level and busy are derived from next-state values so the ports are
    // plain flops that line up exactly with the state they describe
    always_comb begin
        tx_d = 1'b1;
        unique case (state_d)
            S_START: tx_d = 1'b0;
            S_DATA:  tx_d = sh_d[0];
            default: tx_d = 1'b1;
        endcase
        busy_d = (state_d != S_IDLE) || (count_d != '0);
    end

    // ---------------------------------------------------------------------
    // Sequential
    // ---------------------------------------------------------------------

    // Sampler and change-detect history
    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            clk_dut_q  <= 1'b0;
            last_val   <= '0;
            last_valid <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            clk_dut_q <= clk_dut;
            if (push) begin
                last_val   <= dut_out;
                last_valid <= 1'b1;
            end
            // last_val is left alone on a drop so a still-different value retries
            if (drop) begin
                overflow <= 1'b1;
            end
        end
    end

    // FIFO storage, no reset needed: only entries below count are ever read
    always_ff @(posedge CLK) begin
        if (push) begin
            mem[wr_ptr] <= dut_out;
        end
    end

    // FIFO pointers and occupancy, pointers wrap naturally at the depth
    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            count <= count_d;
        end
    end

    // UART state register and outputs
    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            baud    <= '0;
            bit_idx <= '0;
            sh      <= '0;
            tx      <= 1'b1;
            busy    <= 1'b0;
        end else begin
            state   <= state_d;
            baud    <= baud_d;
            bit_idx <= bit_idx_d;
            sh      <= sh_d;
            tx      <= tx_d;
            busy    <= busy_d;
        end
    end

endmodule

// File: tb/tb_tto_output_monitor.sv
// -----------------------------------------------------------------------------
// tb_tto_output_monitor
//
// Two instances: u_a (CLKS_PER_BIT=4, change-only) for framing, change
// filtering, spacing and async abort; u_b (CLKS_PER_BIT=104, every sample)
// for FIFO fill and overflow. A background UART receiver per instance decodes
// tx into a queue of frames, checking every bit holds for a full bit time.
// -----------------------------------------------------------------------------
module tb_tto_output_monitor;

    localparam int unsigned CPB_A = 4;
    localparam int unsigned CPB_B = 104;

    logic       CLK = 1'b0;
    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    logic       rst_a = 1'b1;
    logic       clk_dut_a;
    logic [7:0] dut_out_a;
    logic       tx_a, busy_a, ovf_a;

    logic       rst_b = 1'b1;
    logic       clk_dut_b;
    logic [7:0] dut_out_b;
    logic       tx_b, busy_b, ovf_b;

    tto_output_monitor #(
        .CLKS_PER_BIT(CPB_A), .FIFO_DEPTH_LOG2(2), .CHANGE_ONLY(1'b1)
    ) u_a (
        .CLK(CLK), .rst(rst_a), .clk_dut(clk_dut_a), .dut_out(dut_out_a),
        .tx(tx_a), .busy(busy_a), .overflow(ovf_a)
    );

    tto_output_monitor #(
        .CLKS_PER_BIT(CPB_B), .FIFO_DEPTH_LOG2(2), .CHANGE_ONLY(1'b0)
    ) u_b (
        .CLK(CLK), .rst(rst_b), .clk_dut(clk_dut_b), .dut_out(dut_out_b),
        .tx(tx_b), .busy(busy_b), .overflow(ovf_b)
    );

    typedef struct {
        logic [7:0] data;
        int         start;
        bit         ok;
    } frame_t;

    typedef struct {
        logic [7:0] din;
        bit         exp_frame;
        logic [7:0] exp_byte;
    } vec_t;

    frame_t q_a[$];
    frame_t q_b[$];
    vec_t   vecs[9];

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic txv(input int which);
        return (which == 0) ? tx_a : tx_b;
    endfunction

    // UART receiver: aligned to the first low sample, checks every cycle of each bit
    task automatic rx_loop(input int which, input int cpb);
        frame_t     f;
        logic [9:0] bits;
        forever begin
            @(negedge CLK);
            if (txv(which) === 1'b0) begin
                f.start = cyc;
                f.ok    = 1'b1;
                bits    = '0;
                for (int k = 0; k < 10; k++) begin
                    for (int c = 0; c < cpb; c++) begin
                        if (!(k == 0 && c == 0)) @(negedge CLK);
                        if (c == 0) bits[k] = txv(which);
                        else if (txv(which) !== bits[k]) f.ok = 1'b0;
                    end
                end
                if (bits[0] !== 1'b0 || bits[9] !== 1'b1) f.ok = 1'b0;
                f.data = bits[8:1];
                if (which == 0) q_a.push_back(f);
                else            q_b.push_back(f);
            end
        end
    endtask

    initial rx_loop(0, CPB_A);
    initial rx_loop(1, CPB_B);

    // One clk_dut period of 2*half CLK cycles, value applied at the rising edge
    task automatic period_a(input logic [7:0] v, input int half);
        @(negedge CLK);
        dut_out_a = v;
        clk_dut_a = 1'b1;
        repeat (half) @(negedge CLK);
        clk_dut_a = 1'b0;
        repeat (half - 1) @(negedge CLK);
    endtask

    task automatic period_b(input logic [7:0] v, input int half);
        @(negedge CLK);
        dut_out_b = v;
        clk_dut_b = 1'b1;
        repeat (half) @(negedge CLK);
        clk_dut_b = 1'b0;
        repeat (half - 1) @(negedge CLK);
    endtask

    initial begin
        frame_t f, f1, f2;
        int     t;

        vecs[0] = '{8'hA5, 1'b1, 8'hA5};
        vecs[1] = '{8'hA5, 1'b0, 8'h00};
        vecs[2] = '{8'h01, 1'b1, 8'h01};
        vecs[3] = '{8'h02, 1'b1, 8'h02};
        vecs[4] = '{8'h02, 1'b0, 8'h00};
        vecs[5] = '{8'h03, 1'b1, 8'h03};
        vecs[6] = '{8'h03, 1'b0, 8'h00};
        vecs[7] = '{8'hFF, 1'b1, 8'hFF};
        vecs[8] = '{8'h00, 1'b1, 8'h00};

        clk_dut_a = 1'b0; dut_out_a = 8'h00;
        clk_dut_b = 1'b0; dut_out_b = 8'h00;

        // Reset state
        repeat (3) @(negedge CLK);
        check("rst_tx", tx_a, 1);
        check("rst_busy", busy_a, 0);
        check("rst_overflow", ovf_a, 0);
        check("rst_tx_b", tx_b, 1);
        rst_a = 1'b0;
        rst_b = 1'b0;
        repeat (2) @(negedge CLK);

        // Change-only filtering, one clk_dut period of 200 CLK per vector
        for (int i = 0; i < 9; i++) begin
            period_a(vecs[i].din, 100);
            check($sformatf("vec%0d_nframes", i), q_a.size(), vecs[i].exp_frame ? 1 : 0);
            if (q_a.size() != 0) begin
                f = q_a.pop_front();
                check($sformatf("vec%0d_data", i), f.data, vecs[i].exp_byte);
                check($sformatf("vec%0d_framing", i), f.ok, 1);
            end
            check($sformatf("vec%0d_busy", i), busy_a, 0);
            check($sformatf("vec%0d_overflow", i), ovf_a, 0);
        end

        // dut_out changes on the same edge clk_dut rises; falling-edge sample sees the new value
        @(negedge CLK);
        clk_dut_a = 1'b1;
        dut_out_a = 8'h7E;
        @(negedge CLK);
        clk_dut_a = 1'b0;
        repeat (60) @(negedge CLK);
        check("coincident_nframes", q_a.size(), 1);
        if (q_a.size() != 0) begin
            f = q_a.pop_front();
            check("coincident_data", f.data, 8'h7E);
        end

        // Two queued values: start-to-start spacing 10*CPB+1
        period_a(8'h11, 2);
        period_a(8'h22, 2);
        check("b2b_busy_mid", busy_a, 1);
        repeat (120) @(negedge CLK);
        check("b2b_nframes", q_a.size(), 2);
        if (q_a.size() == 2) begin
            f1 = q_a.pop_front();
            f2 = q_a.pop_front();
            check("b2b_data0", f1.data, 8'h11);
            check("b2b_data1", f2.data, 8'h22);
            check("b2b_spacing", f2.start - f1.start, 10 * CPB_A + 1);
            check("b2b_framing", f1.ok && f2.ok, 1);
        end
        check("b2b_busy_end", busy_a, 0);

        // Async reset midway through DATA bit 3 of 0x34 (bit 3 is 0)
        period_a(8'h34, 2);
        t = 0;
        while (tx_a !== 1'b0 && t < 20) begin
            @(negedge CLK);
            t++;
        end
        check("abort_start_seen", t < 20, 1);
        repeat (18) @(negedge CLK);
        check("abort_tx_bit3", tx_a, 0);
        check("abort_busy_pre", busy_a, 1);
        rst_a = 1'b1;
        #1;
        check("abort_tx_async", tx_a, 1);
        check("abort_busy_async", busy_a, 0);
        repeat (4) @(negedge CLK);
        rst_a = 1'b0;
        repeat (60) @(negedge CLK);
        q_a.delete();
        repeat (100) @(negedge CLK);
        check("abort_no_residual", q_a.size(), 0);
        check("abort_tx_idle", tx_a, 1);
        check("abort_busy_idle", busy_a, 0);

        // Every-sample mode: 1 popped + 4 buffered, 6th sample overflows
        for (int k = 0; k < 6; k++) begin
            period_b(8'h10 + 8'(k), 2);
            check($sformatf("fill_overflow_%0d", k + 1), ovf_b, (k == 5) ? 1 : 0);
        end
        check("fill_busy", busy_b, 1);
        t = 0;
        while (q_b.size() < 5 && t < 7000) begin
            @(negedge CLK);
            t++;
        end
        repeat (20) @(negedge CLK);
        check("fill_nframes", q_b.size(), 5);
        for (int k = 0; k < 5; k++) begin
            if (q_b.size() != 0) begin
                f = q_b.pop_front();
                check($sformatf("fill_data%0d", k), f.data, 8'h10 + 8'(k));
                check($sformatf("fill_framing%0d", k), f.ok, 1);
            end
        end
        check("fill_overflow_sticky", ovf_b, 1);
        check("fill_busy_end", busy_b, 0);
        check("fill_tx_idle", tx_b, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/tto_output_monitor.md
Name: tto_output_monitor

Overview:
Board-side capture path for the TinyTapeout DUT. It samples the DUT's 8-bit output bus once per divided DUT clock period and buffers the samples in a small FIFO. It streams them to the host as 8N1 UART frames on a single pin. It is the readback counterpart to the board top's input drive: the top generates clk_dut and the delayed reset into the DUT, and this block reports what the DUT drives back.

Parameters:
CLKS_PER_BIT, 104, CLK cycles per UART bit (12 MHz / 115200); legal range 2..65535
FIFO_DEPTH_LOG2, 2, log2 of FIFO depth (default 4 entries)
CHANGE_ONLY, 1, 1 = enqueue only samples differing from last enqueued; 0 = enqueue every sample

Ports:
CLK  input  1  board clock; all logic on posedge
rst  input  1  asynchronous, active-high reset
clk_dut  input  1  divided DUT clock, generated from CLK in the CLK domain; no synchroniser required
dut_out  input  8  DUT output bus (top_tto io_out)
tx  output  1  UART transmit, idle high
busy  output  1  high while the FIFO is non-empty or a frame is in progress
overflow  output  1  sticky; set when a sample is dropped because the FIFO is full

Behaviour:
- Reset (async, rst=1): tx=1, busy=0, overflow=0, FIFO empty, last_valid=0, clk_dut_q=0, UART state IDLE. tx returns high in the same cycle rst asserts, aborting any frame in progress.
- Sample point: clk_dut_q is clk_dut registered. sample_stb = !clk_dut & clk_dut_q, i.e. the clk_dut falling edge, mid DUT cycle, when outputs are stable. dut_out is captured on the CLK edge that sees sample_stb.
- Enqueue decision on sample_stb:
  - want = !CHANGE_ONLY | !last_valid | (dut_out != last_val).
  - The first sample after reset is always wanted.
- Push acceptance:
  - A wanted sample is accepted if the FIFO is not full, or if a pop occurs in the same cycle.
  - On accept: last_val <= dut_out, last_valid <= 1.
  - On reject: the sample is dropped, overflow <= 1, and last_val is unchanged, so a still-different value retries at the next sample.
  - overflow clears only on rst.
- FIFO: 2^FIFO_DEPTH_LOG2 entries, circular read/write pointers plus a count of width FIFO_DEPTH_LOG2+1. Pointers wrap modulo depth. Simultaneous push and pop leaves count unchanged. Pop on empty never occurs.
- UART FSM states: IDLE, START, DATA, STOP. Bit counter 0..7; baud counter 0..CLKS_PER_BIT-1.
  - IDLE: tx=1. If the FIFO is non-empty, pop the head into shift register sh and go to START; baud counter resets to 0.
  - START: tx=0 for CLKS_PER_BIT cycles, then DATA with bit=0.
  - DATA: tx=sh[0], LSB first. Each bit lasts CLKS_PER_BIT cycles, then sh shifts right and bit increments. After bit 7, go to STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles, then IDLE.
- tx is registered, never combinational from state.
  - First tx low occurs the cycle after the pop edge.
  - Frame length is 10*CLKS_PER_BIT cycles.
  - Back-to-back frames have exactly one extra IDLE cycle, so start-to-start spacing is 10*CLKS_PER_BIT+1.
- busy = (state != IDLE) | (count != 0), registered or combinational from registers, with no glitches on the port.
- clk_dut stopped (held constant): no sample_stb, no new data; queued frames still drain.
- Widths: all counters are unsigned with no overflow. The baud counter is 16 bits; CLKS_PER_BIT must be ≥2.

Test Plan:
- Reset, CLKS_PER_BIT=4, clk_dut period 200 CLK, dut_out held 0xA5 -> exactly one frame on tx: 0 (start), then 1,0,1,0,0,1,0,1, then 1 (stop), 4 cycles per bit, 40 cycles total; no further frames; busy falls after stop.
- CHANGE_ONLY=1, dut_out 0x01→0x02→0x02→0x03 on successive clk_dut periods -> frames 0x01, 0x02, 0x03 only, in order; overflow stays 0.
- CHANGE_ONLY=0, CLKS_PER_BIT=104, clk_dut period 4 CLK, dut_out incrementing from 0x10 -> frames 0x10..0x14 (1 popped immediately + 4 buffered); overflow=1 after the 6th sample and stays 1.
- rst asserted midway through DATA bit 3 -> tx=1 and busy=0 in the same cycle (async); after release with clk_dut stopped, tx stays high with no residual frame.
- dut_out changes on CLK edge coincident with clk_dut rising, from 0x00 to 0x7E -> captured value at the next falling edge is 0x7E; the pre-change value is never sampled mid-transition.
- Two values queued, CLKS_PER_BIT=4 -> second start bit begins exactly 41 CLK after the first start bit.
